// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - mode codes, FSM state type and width helper for universal_shift_reg
package usr_pkg;

   localparam logic [2:0] M_HOLD = 3'b000;
   localparam logic [2:0] M_SHR  = 3'b001;
   localparam logic [2:0] M_SHL  = 3'b010;
   localparam logic [2:0] M_LOAD = 3'b011;
   localparam logic [2:0] M_ROR  = 3'b100;
   localparam logic [2:0] M_ROL  = 3'b101;
   localparam logic [2:0] M_SRA  = 3'b110;
   localparam logic [2:0] M_RSVD = 3'b111;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic int usr_cnt_w(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/usr_if.sv
// rtl/usr_if.sv - control, data and status bundle of universal_shift_reg
interface usr_if
   import usr_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = usr_cnt_w(WIDTH)
);

   logic [2:0]       mode;
   logic [WIDTH-1:0] din;
   logic             sr_in;
   logic             sl_in;
   logic             en;
   logic             start;
   logic [CNT_W-1:0] amt;
   logic [WIDTH-1:0] q;
   logic             busy;
   logic             done;

   modport master (
      output mode, din, sr_in, sl_in, en, start, amt,
      input  q, busy, done
   );

   modport slave (
      input  mode, din, sr_in, sl_in, en, start, amt,
      output q, busy, done
   );

endinterface

// File: rtl/usr_step.sv
// rtl/usr_step.sv - combinational one-step next value of the shift register
module usr_step
   import usr_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] q_i,
   input  logic [2:0]       mode_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             sr_in_i,
   input  logic             sl_in_i,
   output logic [WIDTH-1:0] q_next_o
);

   always_comb begin
      q_next_o = q_i;
      case (mode_i)
         M_SHR:   q_next_o = {sr_in_i, q_i[WIDTH-1:1]};
         M_SHL:   q_next_o = {q_i[WIDTH-2:0], sl_in_i};
         M_LOAD:  q_next_o = din_i;
         M_ROR:   q_next_o = {q_i[0], q_i[WIDTH-1:1]};
         M_ROL:   q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
         M_SRA:   q_next_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
         default: q_next_o = q_i;
      endcase
   end

endmodule

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - universal shift register with counted multi-shift sequencer
module universal_shift_reg
   import usr_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = usr_cnt_w(WIDTH)
) (
   input  logic clk,
   input  logic rst,
   usr_if.slave bus
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       m_q, m_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             done_q, done_d;

   logic [2:0]       step_mode;
   logic [WIDTH-1:0] q_next;

   // RUN replays the latched mode so live mode changes cannot disturb a counted op
   assign step_mode = (state_q == RUN) ? m_q : bus.mode;

   usr_step #(.WIDTH(WIDTH)) u_step (
      .q_i      (q_q),
      .mode_i   (step_mode),
      .din_i    (bus.din),
      .sr_in_i  (bus.sr_in),
      .sl_in_i  (bus.sl_in),
      .q_next_o (q_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         m_q     <= M_HOLD;
         q_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         m_q     <= m_d;
         q_q     <= q_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      m_d     = m_q;
      q_d     = q_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.mode == M_LOAD) begin
                  q_d    = q_next;
                  done_d = 1'b1;
               end else if (bus.amt == '0) begin
                  done_d = 1'b1;
               end else begin
                  m_d     = bus.mode;
                  cnt_d   = bus.amt;
                  state_d = RUN;
               end
            end else if (bus.en) begin
               q_d = q_next;
            end
         end
         RUN: begin
            q_d   = q_next;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.q    = q_q;
   assign bus.busy = (state_q == RUN);
   assign bus.done = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - directed self-checking bench for universal_shift_reg
module tb_universal_shift_reg;
   import usr_pkg::*;

   localparam int W  = 8;
   localparam int CW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   usr_if #(.WIDTH(W), .CNT_W(CW)) bus ();

   universal_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] q, input logic busy, input logic done);
      chk({tag, "_q"}, 32'(bus.q), 32'(q));
      chk({tag, "_busy"}, 32'(bus.busy), 32'(busy));
      chk({tag, "_done"}, 32'(bus.done), 32'(done));
   endtask

   initial begin
      bus.mode  = M_HOLD;
      bus.din   = '0;
      bus.sr_in = 1'b0;
      bus.sl_in = 1'b0;
      bus.en    = 1'b0;
      bus.start = 1'b0;
      bus.amt   = '0;

      tick();
      tick();
      chk_all("reset", 8'h00, 1'b0, 1'b0);
      rst = 1'b0;

      bus.en = 1'b1; bus.mode = M_LOAD; bus.din = 8'hB4;
      tick(); chk_all("en_load", 8'hB4, 1'b0, 1'b0);
      bus.mode = M_SRA;
      tick(); chk("en_sra", 32'(bus.q), 32'h0DA);
      bus.mode = M_ROL;
      tick(); chk("en_rol", 32'(bus.q), 32'h0B5);

      bus.mode = M_LOAD; bus.din = 8'h81;
      tick(); chk("load81", 32'(bus.q), 32'h081);
      bus.en = 1'b0; bus.start = 1'b1; bus.mode = M_SHL; bus.amt = 3'd3; bus.sl_in = 1'b1;
      tick(); chk_all("shl_e0", 8'h81, 1'b1, 1'b0);
      bus.start = 1'b0; bus.mode = M_HOLD;
      tick(); chk_all("shl_e1", 8'h03, 1'b1, 1'b0);
      tick(); chk_all("shl_e2", 8'h07, 1'b1, 1'b0);
      tick(); chk_all("shl_e3", 8'h0F, 1'b0, 1'b1);
      tick(); chk_all("shl_after", 8'h0F, 1'b0, 1'b0);

      bus.start = 1'b1; bus.mode = M_SHR; bus.amt = 3'd0;
      tick(); chk_all("amt0", 8'h0F, 1'b0, 1'b1);
      bus.start = 1'b0;
      tick(); chk_all("amt0_after", 8'h0F, 1'b0, 1'b0);
      bus.start = 1'b1; bus.mode = M_LOAD; bus.din = 8'h5A; bus.amt = 3'd2;
      tick(); chk_all("start_load", 8'h5A, 1'b0, 1'b1);
      bus.start = 1'b0;
      tick(); chk_all("start_load_after", 8'h5A, 1'b0, 1'b0);

      bus.en = 1'b1; bus.mode = M_LOAD; bus.din = 8'h01;
      tick(); chk("load01", 32'(bus.q), 32'h001);
      bus.en = 1'b0; bus.start = 1'b1; bus.mode = M_ROR; bus.amt = 3'd4;
      tick(); chk_all("ror_e0", 8'h01, 1'b1, 1'b0);
      bus.en = 1'b1; bus.mode = M_LOAD; bus.din = 8'hFF; bus.amt = 3'd7;
      tick(); chk_all("ror_e1", 8'h80, 1'b1, 1'b0);
      bus.en = 1'b0; bus.start = 1'b0;
      tick(); chk_all("ror_e2", 8'h40, 1'b1, 1'b0);
      tick(); chk_all("ror_e3", 8'h20, 1'b1, 1'b0);
      tick(); chk_all("ror_e4", 8'h10, 1'b0, 1'b1);

      bus.start = 1'b1; bus.en = 1'b1; bus.mode = M_SHR; bus.amt = 3'd2; bus.sr_in = 1'b0;
      tick(); chk_all("both_e0", 8'h10, 1'b1, 1'b0);
      bus.start = 1'b0; bus.en = 1'b0;
      tick(); chk_all("both_e1", 8'h08, 1'b1, 1'b0);
      tick(); chk_all("both_e2", 8'h04, 1'b0, 1'b1);

      bus.start = 1'b1; bus.mode = M_SHR; bus.amt = 3'd7;
      tick(); chk_all("abort_e0", 8'h04, 1'b1, 1'b0);
      bus.start = 1'b0;
      tick(); chk("abort_e1", 32'(bus.q), 32'h002);
      tick(); chk("abort_e2", 32'(bus.q), 32'h001);
      #2 rst = 1'b1;
      #1 chk_all("abort_async", 8'h00, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk_all("abort_nodone", 8'h00, 1'b0, 1'b0);
      end

      bus.en = 1'b1; bus.mode = M_LOAD; bus.din = 8'h80;
      tick(); chk("load80", 32'(bus.q), 32'h080);
      bus.en = 1'b0; bus.start = 1'b1; bus.mode = M_ROL; bus.amt = 3'd1;
      tick(); chk_all("b2b_e0", 8'h80, 1'b1, 1'b0);
      tick(); chk_all("b2b_e1", 8'h01, 1'b0, 1'b1);
      tick(); chk_all("b2b_e2", 8'h01, 1'b1, 1'b0);
      bus.start = 1'b0;
      tick(); chk_all("b2b_e3", 8'h02, 1'b0, 1'b1);
      tick(); chk_all("b2b_after", 8'h02, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
